// File: rtl/goomba_collide.sv
// rtl/goomba_collide.sv - goomba/Mario box collision classifier with goomba life-state machine
module goomba_collide #(
    parameter int STOMP_MARGIN  = 4,
    parameter int SQUASH_FRAMES = 30,
    parameter int HURT_COOLDOWN = 60,
    parameter int STOMP_SCORE   = 100
) (
    input  logic       frame_clk,
    input  logic       Reset_n,
    input  logic [9:0] MarioX,
    input  logic [9:0] MarioY,
    input  logic [9:0] MarioXS,
    input  logic [9:0] MarioYS,
    input  logic       mario_falling,
    input  logic [9:0] GoombaX,
    input  logic [9:0] GoombaY,
    input  logic [9:0] GoombaXS,
    input  logic [9:0] GoombaYS,
    input  logic       respawn,
    output logic       goomba_alive,
    output logic       goomba_squash,
    output logic       goomba_visible,
    output logic       stomp_pulse,
    output logic       hurt_pulse,
    output logic [9:0] score_add
);

    localparam int SW = $clog2(SQUASH_FRAMES + 1);
    localparam int CW = $clog2(HURT_COOLDOWN + 1);

    typedef enum logic [1:0] {ALIVE, SQUASHED, DEAD} state_t;

    state_t        state;
    logic [SW-1:0] squash_cnt;
    logic [CW-1:0] cooldown;

    logic [10:0] mx, my, mxs, mys, gx, gy, gxs, gys;
    logic [10:0] dx, dy, mario_bottom, stomp_line;
    logic [11:0] stomp_line_raw;
    logic        overlap, stomp_cond, hurt_cond;

    assign mx  = {1'b0, MarioX};
    assign my  = {1'b0, MarioY};
    assign mxs = {1'b0, MarioXS};
    assign mys = {1'b0, MarioYS};
    assign gx  = {1'b0, GoombaX};
    assign gy  = {1'b0, GoombaY};
    assign gxs = {1'b0, GoombaXS};
    assign gys = {1'b0, GoombaYS};

    always_comb begin
        dx = (mx >= gx) ? (mx - gx) : (gx - mx);
        dy = (my >= gy) ? (my - gy) : (gy - my);
        overlap = (dx < (mxs + gxs)) && (dy < (mys + gys));
        mario_bottom = my + mys;
        // Goomba top plus slack can go negative for a goomba near the screen top; clamp to 0.
        stomp_line_raw = {2'b00, GoombaY} - {2'b00, GoombaYS} + 12'(STOMP_MARGIN);
        stomp_line = stomp_line_raw[11] ? 11'd0 : stomp_line_raw[10:0];
        stomp_cond = overlap && mario_falling && (mario_bottom <= stomp_line);
        hurt_cond  = overlap && !stomp_cond;
    end

    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state          <= ALIVE;
            squash_cnt     <= '0;
            cooldown       <= '0;
            goomba_alive   <= 1'b1;
            goomba_squash  <= 1'b0;
            goomba_visible <= 1'b1;
            stomp_pulse    <= 1'b0;
            hurt_pulse     <= 1'b0;
            score_add      <= '0;
        end else begin
            stomp_pulse <= 1'b0;
            hurt_pulse  <= 1'b0;
            score_add   <= '0;
            if (cooldown != '0)
                cooldown <= cooldown - CW'(1);
            case (state)
                ALIVE: begin
                    if (stomp_cond) begin
                        state         <= SQUASHED;
                        squash_cnt    <= '0;
                        stomp_pulse   <= 1'b1;
                        score_add     <= 10'(STOMP_SCORE);
                        goomba_alive  <= 1'b0;
                        goomba_squash <= 1'b1;
                    end else if (hurt_cond && cooldown == '0) begin
                        hurt_pulse <= 1'b1;
                        // The pulse cycle itself is the first suppressed cycle of the window.
                        cooldown   <= CW'(HURT_COOLDOWN - 1);
                    end
                end
                SQUASHED: begin
                    if (squash_cnt == SW'(SQUASH_FRAMES - 1)) begin
                        state          <= DEAD;
                        squash_cnt     <= '0;
                        goomba_squash  <= 1'b0;
                        goomba_visible <= 1'b0;
                    end else begin
                        squash_cnt <= squash_cnt + SW'(1);
                    end
                end
                DEAD: begin
                    if (respawn) begin
                        state          <= ALIVE;
                        squash_cnt     <= '0;
                        goomba_alive   <= 1'b1;
                        goomba_visible <= 1'b1;
                    end
                end
                default: begin
                    state          <= ALIVE;
                    goomba_alive   <= 1'b1;
                    goomba_squash  <= 1'b0;
                    goomba_visible <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_goomba_collide.sv
// tb/tb_goomba_collide.sv - scoreboard bench for goomba_collide against a frame-time reference model
module tb_goomba_collide;

    localparam int SQUASH_FRAMES = 30;
    localparam int HURT_COOLDOWN = 60;
    localparam int STOMP_SCORE   = 100;
    localparam int STOMP_MARGIN  = 4;

    logic       frame_clk = 1'b0;
    logic       Reset_n;
    logic [9:0] MarioX, MarioY, MarioXS, MarioYS;
    logic       mario_falling;
    logic [9:0] GoombaX, GoombaY, GoombaXS, GoombaYS;
    logic       respawn;
    logic       goomba_alive, goomba_squash, goomba_visible;
    logic       stomp_pulse, hurt_pulse;
    logic [9:0] score_add;

    goomba_collide #(
        .STOMP_MARGIN(STOMP_MARGIN), .SQUASH_FRAMES(SQUASH_FRAMES),
        .HURT_COOLDOWN(HURT_COOLDOWN), .STOMP_SCORE(STOMP_SCORE)
    ) dut (
        .frame_clk(frame_clk), .Reset_n(Reset_n),
        .MarioX(MarioX), .MarioY(MarioY), .MarioXS(MarioXS), .MarioYS(MarioYS),
        .mario_falling(mario_falling),
        .GoombaX(GoombaX), .GoombaY(GoombaY), .GoombaXS(GoombaXS), .GoombaYS(GoombaYS),
        .respawn(respawn),
        .goomba_alive(goomba_alive), .goomba_squash(goomba_squash), .goomba_visible(goomba_visible),
        .stomp_pulse(stomp_pulse), .hurt_pulse(hurt_pulse), .score_add(score_add)
    );

    always #5 frame_clk = ~frame_clk;

    typedef struct packed {
        logic       alive;
        logic       squash;
        logic       visible;
        logic       stomp;
        logic       hurt;
        logic [9:0] score;
    } exp_t;

    exp_t q[$];
    int tests = 0;
    int fails = 0;
    int dut_hurts = 0;

    // Reference model: life phase plus frame timestamps of the last hurt and squash end.
    int cyc = 0;
    int phase = 0;
    int squash_end = 0;
    int last_hurt = -100000;

    function automatic exp_t reset_exp();
        exp_t e;
        e = '{alive: 1'b1, squash: 1'b0, visible: 1'b1, stomp: 1'b0, hurt: 1'b0, score: 10'd0};
        return e;
    endfunction

    task automatic step();
        exp_t e;
        int dx, dy, line;
        bit ov, st, hu;
        st = 0;
        hu = 0;
        if (!Reset_n) begin
            phase = 0;
            last_hurt = -100000;
            e = reset_exp();
        end else begin
            if (phase == 0) begin
                dx = int'(MarioX) - int'(GoombaX);
                if (dx < 0) dx = -dx;
                dy = int'(MarioY) - int'(GoombaY);
                if (dy < 0) dy = -dy;
                ov = (dx < int'(MarioXS) + int'(GoombaXS)) && (dy < int'(MarioYS) + int'(GoombaYS));
                line = int'(GoombaY) - int'(GoombaYS) + STOMP_MARGIN;
                if (line < 0) line = 0;
                if (ov && mario_falling && (int'(MarioY) + int'(MarioYS) <= line)) begin
                    st = 1;
                    phase = 1;
                    squash_end = cyc + SQUASH_FRAMES;
                end else if (ov && (cyc - last_hurt >= HURT_COOLDOWN)) begin
                    hu = 1;
                    last_hurt = cyc;
                end
            end else if (phase == 1) begin
                if (cyc == squash_end) phase = 2;
            end else begin
                if (respawn) phase = 0;
            end
            e.alive   = (phase == 0);
            e.squash  = (phase == 1);
            e.visible = (phase != 2);
            e.stomp   = st;
            e.hurt    = hu;
            e.score   = st ? 10'(STOMP_SCORE) : 10'd0;
        end
        q.push_back(e);
        cyc++;
        @(negedge frame_clk);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic set_mario(input int x, input int y, input int xs, input int ys, input bit f);
        MarioX = 10'(x); MarioY = 10'(y); MarioXS = 10'(xs); MarioYS = 10'(ys);
        mario_falling = f;
    endtask

    task automatic set_goomba(input int x, input int y, input int xs, input int ys);
        GoombaX = 10'(x); GoombaY = 10'(y); GoombaXS = 10'(xs); GoombaYS = 10'(ys);
    endtask

    task automatic async_reset(input string name);
        exp_t r;
        Reset_n = 1'b0;
        #1;
        r = reset_exp();
        tests++;
        if ({goomba_alive, goomba_squash, goomba_visible, stomp_pulse, hurt_pulse, score_add} != r) begin
            fails++;
            $display("FAIL %s: async reset got alive=%b squash=%b vis=%b stomp=%b hurt=%b score=%0d, want 1 0 1 0 0 0",
                     name, goomba_alive, goomba_squash, goomba_visible, stomp_pulse, hurt_pulse, score_add);
        end
        step();
        Reset_n = 1'b1;
    endtask

    task automatic check_count(input string name, input int got, input int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    // Monitor: pops one expected record per frame edge and compares all outputs.
    initial begin
        exp_t e;
        forever begin
            @(posedge frame_clk);
            #1;
            if (hurt_pulse) dut_hurts++;
            if (q.size() > 0) begin
                e = q.pop_front();
                tests++;
                if ({goomba_alive, goomba_squash, goomba_visible, stomp_pulse, hurt_pulse, score_add} != e) begin
                    fails++;
                    $display("FAIL outputs @%0t: got alive=%b squash=%b vis=%b stomp=%b hurt=%b score=%0d, want alive=%b squash=%b vis=%b stomp=%b hurt=%b score=%0d",
                             $time, goomba_alive, goomba_squash, goomba_visible, stomp_pulse, hurt_pulse, score_add,
                             e.alive, e.squash, e.visible, e.stomp, e.hurt, e.score);
                end
            end
        end
    end

    initial begin
        int h0, t, len;
        Reset_n = 1'b0;
        respawn = 1'b0;
        set_goomba(280, 399, 16, 16);
        set_mario(280, 399, 16, 16, 1'b0);
        @(negedge frame_clk);
        steps(3);
        Reset_n = 1'b1;
        set_mario(100, 399, 16, 16, 1'b0);
        steps(5);

        // Stomp, squash for SQUASH_FRAMES, dead, respawn attempt while dead.
        set_mario(280, 370, 16, 16, 1'b1);
        step();
        set_mario(100, 370, 16, 16, 1'b0);
        steps(35);
        respawn = 1'b1;
        step();
        respawn = 1'b0;
        steps(3);

        // Second stomp: respawn held during squash is ignored, then reset mid-squash.
        set_mario(280, 370, 16, 16, 1'b1);
        step();
        set_mario(100, 370, 16, 16, 1'b0);
        respawn = 1'b1;
        steps(10);
        respawn = 1'b0;
        async_reset("mid_squash");
        steps(2);

        // Side hurt held 200 frames.
        set_mario(260, 399, 8, 16, 1'b0);
        h0 = dut_hurts;
        steps(200);
        check_count("side_hurt_count", dut_hurts - h0, 4);
        set_mario(100, 399, 8, 16, 1'b0);
        steps(61);

        // Edge touch is not contact; one pixel closer is.
        set_mario(248, 399, 16, 16, 1'b0);
        steps(3);
        set_mario(249, 399, 16, 16, 1'b0);
        steps(3);
        set_mario(100, 399, 16, 16, 1'b0);
        steps(61);

        // Stomp margin boundary: bottom 387 stomps, 388 hurts.
        set_mario(280, 371, 16, 16, 1'b1);
        step();
        set_mario(100, 371, 16, 16, 1'b0);
        steps(32);
        respawn = 1'b1;
        step();
        respawn = 1'b0;
        set_mario(280, 372, 16, 16, 1'b1);
        h0 = dut_hurts;
        steps(3);
        check_count("margin_hurt_count", dut_hurts - h0, 1);
        async_reset("cooldown_running");

        // Randomised segments around the goomba, including near-top goombas.
        for (int s = 0; s < 600; s++) begin
            if ($urandom_range(0, 1) == 0)
                set_goomba($urandom_range(0, 1023), $urandom_range(0, 3) == 0 ? $urandom_range(0, 40) : $urandom_range(0, 1023),
                           $urandom_range(0, 40), $urandom_range(0, 40));
            t = int'(GoombaX) + int'($urandom_range(0, 100)) - 50;
            MarioX = 10'(t < 0 ? 0 : (t > 1023 ? 1023 : t));
            t = int'(GoombaY) + int'($urandom_range(0, 100)) - 50;
            MarioY = 10'(t < 0 ? 0 : (t > 1023 ? 1023 : t));
            MarioXS = 10'($urandom_range(0, 40));
            MarioYS = 10'($urandom_range(0, 40));
            mario_falling = 1'($urandom_range(0, 1));
            respawn = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 99) == 0) async_reset("random_reset");
            len = $urandom_range(1, 8);
            steps(len);
        end

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge frame_clk);
        check_count("scoreboard_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
